mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the word-wide data memory in the multicycle MIPS datapath.
- Accepts one load or store request at a time from the control unit: LW/LH/LHU/LB/LBU and SW/SH/SB.
- Drives the memory's word read/write port; sub-word stores are done as read-modify-write.
- Returns the aligned, extended load data with a one-cycle done pulse; flags misaligned accesses.

Parameters:
- ADDR_W, 12, byte-address width seen by memory; word index is addr[ADDR_W-1:2].

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  reset, synchronous and active-high.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data, right-justified for sub-word stores.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  misalignment flag, valid while done = 1.
- rdata  output  32  load result, holds until the next completed load.
- mem_raddr  output  ADDR_W-2  to memory read address.
- mem_waddr  output  ADDR_W-2  to memory write address.
- mem_din  output  32  to memory write data.
- mem_wren  output  1  to memory write enable.
- mem_dout  input  32  from memory; combinational read of mem_raddr.

Behaviour:
- Reset: state = IDLE; busy, done, err, mem_wren = 0; rdata, latched addr/data/control, mem_din = 0.
- Reset mid-operation aborts the access with no write.
  - mem_wren = (state == WRITE) && !rst, so a reset during WRITE suppresses the write that edge.
  - No done pulse is produced for an aborted access.
- Byte order is little-endian: byte k = bits [8k+7:8k]; halfword h = bits [16h+15:16h].
- Accept: in IDLE with req = 1, latch we, size, uns, addr and wdata.
- Accept: check alignment at the same edge.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
  - A misaligned request goes directly to DONE with err = 1.
  - No memory write occurs and rdata is unchanged.
- States and transitions:
  - IDLE -> READ on an aligned load or a sub-word store.
  - IDLE -> WRITE on an aligned word store.
  - IDLE -> DONE on a misaligned request.
  - READ, load: rdata <= extracted and extended lane of mem_dout; -> DONE.
  - READ, sub-word store: mem_din <= mem_dout with the addressed lane replaced by wdata[7:0] or wdata[15:0]; -> WRITE.
  - WRITE: mem_wren = 1 for exactly one cycle; memory commits at the edge leaving WRITE; -> DONE.
  - Word store: mem_din <= wdata at accept.
  - DONE: done = 1, err valid; -> IDLE unconditionally.
- mem_raddr and mem_waddr both equal latched addr[ADDR_W-1:2] in every state.
- mem_wren is 0 outside WRITE.
- Latency, counted as cycles from the accepting edge to the done cycle:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Misaligned request: 1.
- req while busy is ignored, not queued.
  - req in the DONE cycle is also ignored; a new request is accepted only from IDLE.
- Extension: LB/LH replicate the sign bit of the selected lane; LBU/LHU zero-fill; LW passes mem_dout unchanged.
- Address bits at and above ADDR_W do not exist on the port; wrap-around is implicit modulo 2^ADDR_W.

Test Plan:
- Word 0x10 preloaded 0x80FF7F01: LB addr 0x13 -> rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01; each done 2 cycles after accept, err = 0.
- SB wdata 0x000000AB to addr 0x11 on word 0x11223344 -> exactly one mem_wren cycle, word becomes 0x1122AB44, done on cycle 3; then LW 0x10 returns 0x1122AB44.
- SW 0xDEADBEEF to addr 0x20 -> no READ state, mem_wren one cycle, done on cycle 2; SH 0xCAFE to 0x22 -> word 0xCAFEBEEF.
- LH at 0x21 and SW at 0x22 -> done 1 cycle after accept, err = 1, mem_wren never asserted, rdata unchanged.
- rst asserted during WRITE of an SB -> mem_wren forced 0, memory word unchanged, next cycle busy = 0, done = 0, rdata = 0.
- req held high continuously with back-to-back LWs -> second request accepted only in IDLE after the DONE cycle; requests during busy are dropped.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a word-wide data memory.
// Accepts one LW/LH/LHU/LB/LBU/SW/SH/SB request at a time. Sub-word stores
// are done as read-modify-write. Loads return the aligned lane, sign- or
// zero-extended, together with a one-cycle done pulse. Misaligned requests
// complete immediately with err set, and they touch neither memory nor rdata.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   req              request strobe, sampled only while idle
//   we               1 = store, 0 = load
//   size             00 byte, 01 halfword, 1x word
//   uns              load zero-extend (1) / sign-extend (0)
//   addr             byte address
//   wdata            store data, right-justified for sub-word stores
//   busy             high whenever not idle
//   done             one-cycle completion pulse
//   err              misalignment flag, valid with done
//   rdata            last completed load result
//   mem_raddr/waddr  word index to memory
//   mem_din          memory write data
//   mem_wren         memory write enable
//   mem_dout         combinational memory read data of mem_raddr
module mem_access_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-3:0] mem_raddr,
    output logic [ADDR_W-3:0] mem_waddr,
    output logic [31:0]       mem_din,
    output logic              mem_wren,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;   // only the sub-word part is needed after accept
    logic              err_q;

    logic        misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // size[1] covers both 10 and 11, which behave as word accesses
    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned)         state_nx = DONE;
                    else if (we && size[1]) state_nx = WRITE;
                    else                    state_nx = READ;
                end
            end
            READ:    state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_sel = mem_dout[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_dout[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_dout;
        endcase
        merged = mem_dout;
        if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mem_din <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        addr_q  <= addr;
                        wdata_q <= wdata[15:0];
                        err_q   <= misaligned;
                        if (we && size[1]) mem_din <= wdata;
                    end
                end
                READ: begin
                    if (we_q) mem_din <= merged;
                    else      rdata   <= load_val;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = done && err_q;
    // rst gates the enable directly so a reset in WRITE blocks the commit edge
    assign mem_wren  = (state == WRITE) && !rst;
    assign mem_raddr = addr_q[ADDR_W-1:2];
    assign mem_waddr = addr_q[ADDR_W-1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// load/store traffic compared against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int ADDR_W = 12;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = '0;
    logic              uns = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              busy, done, err, mem_wren;
    logic [31:0]       rdata, mem_din, mem_dout;
    logic [ADDR_W-3:0] mem_raddr, mem_waddr;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    logic        init_req = 1'b0;
    logic [31:0] exp_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory behind the DUT; init_req reloads it wholesale from ref_mem
    assign mem_dout = mem[mem_raddr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= ref_mem[i];
        end else if (mem_wren) begin
            mem[mem_waddr] <= mem_din;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic sync_mem();
        @(negedge clk); init_req = 1'b1;
        @(negedge clk); init_req = 1'b0;
    endtask

    // Reference: expected latency, err, write count; updates ref_mem/exp_rdata
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         output int lat, output logic e, output int wr);
        int unsigned off, idx;
        longint      v;
        logic [31:0] word, mask;
        bit          mis;
        off  = a % 4;
        idx  = a / 4;
        word = ref_mem[idx];
        mis  = (sz == 1 && (off % 2) != 0) || (sz >= 2 && off != 0);
        if (mis) begin
            lat = 1; e = 1'b1; wr = 0;
            return;
        end
        e = 1'b0;
        if (!w) begin
            lat = 2; wr = 0;
            if (sz == 0) begin
                v = (word >> (8 * off)) & 32'hFF;
                if (!u && v >= 128) v -= 256;
            end else if (sz == 1) begin
                v = (word >> (8 * off)) & 32'hFFFF;
                if (!u && v >= 32768) v -= 65536;
            end else begin
                v = word;
            end
            exp_rdata = 32'(v);
        end else begin
            wr = 1;
            if (sz >= 2) begin
                lat = 2;
                ref_mem[idx] = d;
            end else begin
                lat  = 3;
                mask = (sz == 0) ? 32'hFF : 32'hFFFF;
                ref_mem[idx] = (word & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
            end
        end
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d, input string tag);
        int   lat, wr, cyc, wcnt, n;
        logic e;
        bit   got;
        @(negedge clk);
        n = 0;
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        model(w, sz, u, a, d, lat, e, wr);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        wdata = $urandom;
        cyc = 1; wcnt = 0; got = 1'b0;
        while (!got && cyc <= 8) begin
            if (mem_wren) wcnt++;
            if (done) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq({tag, " latency"}, cyc, lat);
        check_eq({tag, " err"}, {31'b0, err}, {31'b0, e});
        check_eq({tag, " wren_cycles"}, wcnt, wr);
        check_eq({tag, " rdata"}, rdata, exp_rdata);
        check_eq({tag, " mem_word"}, mem[a / 4], ref_mem[a / 4]);
        check_eq({tag, " raddr"}, {22'b0, mem_raddr}, {22'b0, a[ADDR_W-1:2]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = $urandom;
        init_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        check_eq("rst busy", {31'b0, busy}, 32'h0);
        check_eq("rst done", {31'b0, done}, 32'h0);
        check_eq("rst err", {31'b0, err}, 32'h0);
        check_eq("rst wren", {31'b0, mem_wren}, 32'h0);
        check_eq("rst rdata", rdata, 32'h0);
        check_eq("rst mem_din", mem_din, 32'h0);
        rst = 1'b0;

        // Loads from a known pattern
        ref_mem[4] = 32'h80FF7F01;
        sync_mem();
        do_op(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, "LB 13");
        do_op(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, "LBU 13");
        do_op(1'b0, 2'b01, 1'b0, 12'h012, 32'h0, "LH 12");
        do_op(1'b0, 2'b01, 1'b1, 12'h010, 32'h0, "LHU 10");
        check_eq("LHU value", exp_rdata, 32'h00007F01);

        // Read-modify-write byte store, then readback
        ref_mem[4] = 32'h11223344;
        sync_mem();
        do_op(1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AB, "SB 11");
        check_eq("SB word", mem[4], 32'h1122AB44);
        do_op(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, "LW 10");

        // Word store followed by halfword store
        do_op(1'b1, 2'b10, 1'b0, 12'h020, 32'hDEADBEEF, "SW 20");
        do_op(1'b1, 2'b01, 1'b0, 12'h022, 32'h0000CAFE, "SH 22");
        check_eq("SH word", mem[8], 32'hCAFEBEEF);

        // Misaligned requests
        do_op(1'b0, 2'b01, 1'b0, 12'h021, 32'h0, "LH 21 mis");
        do_op(1'b1, 2'b10, 1'b0, 12'h022, 32'h12345678, "SW 22 mis");
        do_op(1'b1, 2'b11, 1'b0, 12'h041, 32'h12345678, "SW size3 mis");

        // Reset during the WRITE cycle of a byte store
        ref_mem[12] = 32'h55667788;
        sync_mem();
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 12'h031; wdata = 32'h99;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check_eq("abort wren before rst", {31'b0, mem_wren}, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("abort wren under rst", {31'b0, mem_wren}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort busy", {31'b0, busy}, 32'h0);
        check_eq("abort done", {31'b0, done}, 32'h0);
        check_eq("abort rdata", rdata, 32'h0);
        check_eq("abort mem_word", mem[12], 32'h55667788);
        exp_rdata = 32'h0;

        // req held high: requests while busy or in DONE are dropped
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 12'h010;
        @(posedge clk); #1;
        addr = 12'h020;
        check_eq("b2b c1 busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1;
        check_eq("b2b c2 done", {31'b0, done}, 32'h1);
        check_eq("b2b first rdata", rdata, ref_mem[4]);
        @(posedge clk); #1;
        check_eq("b2b c3 idle", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        check_eq("b2b c4 busy", {31'b0, busy}, 32'h1);
        check_eq("b2b c4 done", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        req = 1'b0;
        check_eq("b2b c5 done", {31'b0, done}, 32'h1);
        check_eq("b2b second rdata", rdata, ref_mem[8]);
        exp_rdata = ref_mem[8];

        // Random traffic over a small window so stores and loads collide
        for (int k = 0; k < 80; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'($urandom_range(0, 63));
            do_op(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
